mem_bus_controller: RTL and testbench

- Sequential, parametrised successor to the combinational address-decode memory controller.
- Accepts one load/store at a time over a valid/ready request channel and decodes it into four regions: code (RO), memory (RW), input (RO), output (RW).
- Inserts per-region wait states, returns sign- or zero-extended read data with an error flag on a one-cycle response strobe.
- Sits between the core's load/store unit and the code ROM, data RAM and I/O ports.

---
 rtl/mem_bus_controller.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_mem_bus_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_controller.sv
// mem_bus_controller
//   Sequential load/store controller sitting between the core's load/store
//   unit and the code ROM, data RAM and I/O ports. One request at a time is
//   accepted over a valid/ready channel. The request is decoded into one of
//   four regions: code (RO), memory (RW), input (RO) and output (RW).
//   Per-region wait states are inserted, and a one-cycle response strobe
//   returns extended read data together with an error flag.
//
// Optional feature macro: FAULT_CAPTURE_EN
//   - Defined: the first fault is latched into fault_valid, fault_addr and
//     fault_cause, and is held until fault_clear.
//   - Undefined: the fault outputs are tied to 0 and fault_clear is ignored.
//
// Ports
//   clk, rst_n                          clock (rising edge), async active-low reset
//   req_valid/req_ready                 request handshake (ready == idle)
//   req_addr/we/size/signed/wdata       request fields, captured on accept
//   resp_valid/resp_rdata/resp_error    one-cycle response
//   code_*, mem_*, in_*, out_*          region-relative target interfaces
//   fault_clear/valid/addr/cause        sticky first-fault record (optional)
module mem_bus_controller #(
    parameter int ADDR_W    = 32,
    parameter int CODE_BASE = 0,
    parameter int CODE_SIZE = 256,
    parameter int MEM_BASE  = 256,
    parameter int MEM_SIZE  = 256,
    parameter int IN_BASE   = 512,
    parameter int IN_SIZE   = 4,
    parameter int OUT_BASE  = 516,
    parameter int OUT_SIZE  = 4,
    parameter int MEM_WAIT  = 1,
    parameter int IO_WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] code_addr,
    input  logic [31:0]       code_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_rdata,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_wdata,
    output logic [1:0]        out_size,
    output logic              out_we,
    input  logic [31:0]       out_rdata,
    input  logic              fault_clear,
    output logic              fault_valid,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [1:0]        fault_cause
);
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ACCESS = 2'b01, ST_RESP = 2'b10} state_t;
    typedef enum logic [1:0] {RG_CODE = 2'b00, RG_MEM = 2'b01, RG_IN = 2'b10, RG_OUT = 2'b11} region_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b00;
    localparam logic [1:0] CAUSE_SIZE     = 2'b01;
    localparam logic [1:0] CAUSE_UNMAP    = 2'b10;
    localparam logic [1:0] CAUSE_WP       = 2'b11;

    // Region bounds as base and (size-1), one bit wider than the address so
    // the end-of-access carry never aliases back into a low region.
    localparam logic [ADDR_W:0] CODE_LO   = (ADDR_W+1)'(CODE_BASE);
    localparam logic [ADDR_W:0] CODE_SPAN = (ADDR_W+1)'(CODE_SIZE - 1);
    localparam logic [ADDR_W:0] MEM_LO    = (ADDR_W+1)'(MEM_BASE);
    localparam logic [ADDR_W:0] MEM_SPAN  = (ADDR_W+1)'(MEM_SIZE - 1);
    localparam logic [ADDR_W:0] IN_LO     = (ADDR_W+1)'(IN_BASE);
    localparam logic [ADDR_W:0] IN_SPAN   = (ADDR_W+1)'(IN_SIZE - 1);
    localparam logic [ADDR_W:0] OUT_LO    = (ADDR_W+1)'(OUT_BASE);
    localparam logic [ADDR_W:0] OUT_SPAN  = (ADDR_W+1)'(OUT_SIZE - 1);
    localparam logic [ADDR_W:0] OFF_HALF  = {{(ADDR_W-1){1'b0}}, 2'b01};
    localparam logic [ADDR_W:0] OFF_WORD  = {{(ADDR_W-1){1'b0}}, 2'b11};
    localparam logic [3:0]      MEM_WAIT_C = 4'(MEM_WAIT);
    localparam logic [3:0]      IO_WAIT_C  = 4'(IO_WAIT);

    // The whole access [start, last] must fall inside [lo, lo+span].
    // A negative start offset shows up as the top bit of the wide subtraction.
    function automatic logic in_region(input logic [ADDR_W:0] start, input logic [ADDR_W:0] last,
                                       input logic [ADDR_W:0] lo, input logic [ADDR_W:0] span);
        logic [ADDR_W:0] rel_start;
        logic [ADDR_W:0] rel_last;
        rel_start = start - lo;
        rel_last  = last - lo;
        return (rel_start[ADDR_W] == 1'b0) && (rel_last <= span);
    endfunction

    // Truncate the raw target word to the access size, then sign- or zero-extend it.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size, input logic sgn);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01:   res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    state_t          state_r, state_n;
    region_t         region_r, region_s;
    logic [ADDR_W-1:0] addr_r;
    logic            we_r, signed_r;
    logic [1:0]      size_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wait_r, wait_s;
    logic            resp_valid_r, resp_error_r;
    logic [31:0]     resp_rdata_r;
    logic [ADDR_W:0] off_s, start_s, last_s;
    logic            hit_code_s, hit_mem_s, hit_in_s, hit_out_s, any_hit_s, misalign_s;
    logic            fault_s;
    logic [1:0]      cause_s;
    logic            accept_s, done_s;
    logic [31:0]     rdata_sel_s;

    assign start_s    = {1'b0, req_addr};
    assign last_s     = start_s + off_s;
    assign hit_code_s = in_region(start_s, last_s, CODE_LO, CODE_SPAN);
    assign hit_mem_s  = in_region(start_s, last_s, MEM_LO, MEM_SPAN);
    assign hit_in_s   = in_region(start_s, last_s, IN_LO, IN_SPAN);
    assign hit_out_s  = in_region(start_s, last_s, OUT_LO, OUT_SPAN);
    assign any_hit_s  = hit_code_s | hit_mem_s | hit_in_s | hit_out_s;
    assign accept_s   = req_valid && (state_r == ST_IDLE);
    assign done_s     = (state_r == ST_ACCESS) && (wait_r == 4'd0);

    // Byte offset of the last byte and the alignment check for the incoming request.
    always_comb begin
        off_s      = {(ADDR_W+1){1'b0}};
        misalign_s = 1'b0;
        case (req_size)
            2'b01: begin
                off_s      = OFF_HALF;
                misalign_s = req_addr[0];
            end
            2'b10: begin
                off_s      = OFF_WORD;
                misalign_s = |req_addr[1:0];
            end
            default: begin
                off_s      = {(ADDR_W+1){1'b0}};
                misalign_s = 1'b0;
            end
        endcase
    end

    // Region select, wait count and fault classification of the incoming request.
    // Alignment is only enforced on accesses that land wholly in a data/IO region;
    // code tolerates unaligned fetches, and accesses that fit no region report unmapped.
    always_comb begin
        region_s = RG_CODE;
        wait_s   = 4'd0;
        fault_s  = 1'b0;
        cause_s  = CAUSE_MISALIGN;
        if (hit_code_s) begin
            region_s = RG_CODE;
            wait_s   = 4'd0;
        end else if (hit_mem_s) begin
            region_s = RG_MEM;
            wait_s   = MEM_WAIT_C;
        end else if (hit_in_s) begin
            region_s = RG_IN;
            wait_s   = IO_WAIT_C;
        end else if (hit_out_s) begin
            region_s = RG_OUT;
            wait_s   = IO_WAIT_C;
        end else begin
            region_s = RG_CODE;
            wait_s   = 4'd0;
        end
        if (req_size == 2'b11) begin
            fault_s = 1'b1;
            cause_s = CAUSE_SIZE;
        end else if (any_hit_s && (region_s != RG_CODE) && misalign_s) begin
            fault_s = 1'b1;
            cause_s = CAUSE_MISALIGN;
        end else if (!any_hit_s) begin
            fault_s = 1'b1;
            cause_s = CAUSE_UNMAP;
        end else if (req_we && ((region_s == RG_CODE) || (region_s == RG_IN))) begin
            fault_s = 1'b1;
            cause_s = CAUSE_WP;
        end else begin
            fault_s = 1'b0;
            cause_s = CAUSE_MISALIGN;
        end
    end

    // Next-state logic of the IDLE -> ACCESS -> RESP sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n = fault_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wait_r == 4'd0) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_ACCESS;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Read data of the region selected by the captured request.
    always_comb begin
        rdata_sel_s = 32'h0000_0000;
        case (region_r)
            RG_CODE: rdata_sel_s = code_rdata;
            RG_MEM:  rdata_sel_s = mem_rdata;
            RG_IN:   rdata_sel_s = in_rdata;
            RG_OUT:  rdata_sel_s = out_rdata;
            default: rdata_sel_s = 32'h0000_0000;
        endcase
    end

    // State, request capture, wait countdown and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            region_r     <= RG_CODE;
            addr_r       <= {ADDR_W{1'b0}};
            we_r         <= 1'b0;
            size_r       <= 2'b00;
            signed_r     <= 1'b0;
            wdata_r      <= 32'h0000_0000;
            wait_r       <= 4'd0;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_n;
            if (accept_s) begin
                region_r <= region_s;
                addr_r   <= req_addr;
                we_r     <= req_we;
                size_r   <= req_size;
                signed_r <= req_signed;
                wdata_r  <= req_wdata;
                wait_r   <= wait_s;
            end else if ((state_r == ST_ACCESS) && (wait_r != 4'd0)) begin
                wait_r <= wait_r - 4'd1;
            end
            if (accept_s && fault_s) begin
                resp_valid_r <= 1'b1;
                resp_error_r <= 1'b1;
                resp_rdata_r <= 32'h0000_0000;
            end else if (done_s) begin
                resp_valid_r <= 1'b1;
                resp_error_r <= 1'b0;
                resp_rdata_r <= we_r ? 32'h0000_0000 : extend(rdata_sel_s, size_r, signed_r);
            end else begin
                resp_valid_r <= 1'b0;
                resp_error_r <= 1'b0;
                resp_rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign req_ready  = (state_r == ST_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_error = resp_error_r;
    assign resp_rdata = resp_rdata_r;
    assign code_addr  = addr_r - CODE_LO[ADDR_W-1:0];
    assign mem_addr   = addr_r - MEM_LO[ADDR_W-1:0];
    assign in_addr    = addr_r - IN_LO[ADDR_W-1:0];
    assign out_addr   = addr_r - OUT_LO[ADDR_W-1:0];
    assign mem_wdata  = wdata_r;
    assign out_wdata  = wdata_r;
    assign mem_size   = size_r;
    assign out_size   = size_r;
    // Write strobes fire only in the final ACCESS cycle; faulted requests never enter ACCESS.
    assign mem_we     = done_s && we_r && (region_r == RG_MEM);
    assign out_we     = done_s && we_r && (region_r == RG_OUT);

`ifdef FAULT_CAPTURE_EN
    logic              fault_valid_r;
    logic [ADDR_W-1:0] fault_addr_r;
    logic [1:0]        fault_cause_r;

    // First-fault record; a fault arriving together with fault_clear wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_valid_r <= 1'b0;
            fault_addr_r  <= {ADDR_W{1'b0}};
            fault_cause_r <= 2'b00;
        end else if (accept_s && fault_s && (!fault_valid_r || fault_clear)) begin
            fault_valid_r <= 1'b1;
            fault_addr_r  <= req_addr;
            fault_cause_r <= cause_s;
        end else if (fault_clear) begin
            fault_valid_r <= 1'b0;
            fault_addr_r  <= {ADDR_W{1'b0}};
            fault_cause_r <= 2'b00;
        end
    end

    assign fault_valid = fault_valid_r;
    assign fault_addr  = fault_addr_r;
    assign fault_cause = fault_cause_r;
`else
    logic unused_fault_clear_s;
    assign unused_fault_clear_s = fault_clear;
    assign fault_valid = 1'b0;
    assign fault_addr  = {ADDR_W{1'b0}};
    assign fault_cause = 2'b00;
`endif

endmodule

// File: tb/tb_mem_bus_controller.sv
// Self-checking bench for mem_bus_controller (default parameters).
module tb_mem_bus_controller;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_signed;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_error;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] code_addr, mem_addr, in_addr, out_addr, fault_addr;
    logic [31:0]   code_rdata, mem_rdata, in_rdata, out_rdata, mem_wdata, out_wdata;
    logic [1:0]    mem_size, out_size, fault_cause;
    logic          mem_we, out_we, fault_clear, fault_valid;

    always #5 clk = ~clk;

    mem_bus_controller dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .code_addr(code_addr), .code_rdata(code_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .in_addr(in_addr), .in_rdata(in_rdata),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_size(out_size), .out_we(out_we), .out_rdata(out_rdata),
        .fault_clear(fault_clear), .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_cause(fault_cause)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Expected outcome of one request, derived from the region map and access rules.
    typedef struct {
        logic        err;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          lat;
        int          reg_idx;
    } exp_t;

    function automatic exp_t model(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic sg);
        longint base_a [4];
        longint size_a [4];
        int     wait_a [4];
        bit     ro_a   [4];
        longint la, len, mask;
        logic [31:0] data;
        int hit;
        exp_t e;
        base_a[0] = 0;   size_a[0] = 256; wait_a[0] = 0; ro_a[0] = 1'b1;
        base_a[1] = 256; size_a[1] = 256; wait_a[1] = 1; ro_a[1] = 1'b0;
        base_a[2] = 512; size_a[2] = 4;   wait_a[2] = 2; ro_a[2] = 1'b1;
        base_a[3] = 516; size_a[3] = 4;   wait_a[3] = 2; ro_a[3] = 1'b0;
        e.err = 1'b0; e.cause = 2'b00; e.rdata = 32'h0; e.lat = 1; e.reg_idx = -1;
        if (sz == 2'b11) begin
            e.err = 1'b1; e.cause = 2'b01;
            return e;
        end
        la  = longint'(a);
        len = longint'(1) << sz;
        hit = -1;
        for (int r = 0; r < 4; r++)
            if (la >= base_a[r] && la + len - 1 <= base_a[r] + size_a[r] - 1) hit = r;
        if (hit < 0) begin
            e.err = 1'b1; e.cause = 2'b10;
        end else if (hit != 0 && (la % len) != 0) begin
            e.err = 1'b1; e.cause = 2'b00;
        end else if (we && ro_a[hit]) begin
            e.err = 1'b1; e.cause = 2'b11;
        end else begin
            e.lat = wait_a[hit] + 2;
            e.reg_idx = hit;
            if (!we) begin
                case (hit)
                    0: data = code_rdata;
                    1: data = mem_rdata;
                    2: data = in_rdata;
                    default: data = out_rdata;
                endcase
                mask = (longint'(1) << (8 * len)) - 1;
                e.rdata = data & mask[31:0];
                if (sg && len < 4 && data[8 * len - 1]) e.rdata = e.rdata | ~mask[31:0];
            end
        end
        return e;
    endfunction

    // Shared state between driver and compare process.
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          active = 1'b0;
    bit          idle_chk = 1'b0;
    bit          clr_on_accept = 1'b0;
    exp_t        cur;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_we;
    int          cmp_n;
    int          last_n = -1;
    logic [31:0] last_rdata;
    logic        last_err;
    int          mem_we_cnt = 0, out_we_cnt = 0, out_we_n = -1;
    logic [31:0] out_addr_seen;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every falling edge checks the DUT against the model.
    always @(negedge clk) begin
        cmp_n = cyc - acc_cyc;
        if (mem_we) mem_we_cnt++;
        if (out_we) begin
            out_we_cnt++;
            out_we_n = cmp_n;
            out_addr_seen = out_addr;
        end
        if (active && cmp_n <= cur.lat) begin
            chk("ready_busy", req_ready, 1'b0);
            chk("resp_valid", resp_valid, cmp_n == cur.lat);
            chk("mem_we", mem_we, (cmp_n == cur.lat - 1) && !cur.err && cur_we && cur.reg_idx == 1);
            chk("out_we", out_we, (cmp_n == cur.lat - 1) && !cur.err && cur_we && cur.reg_idx == 3);
            if (mem_we) begin
                chk("mem_addr", mem_addr, cur_addr - 32'd256);
                chk("mem_wdata", mem_wdata, cur_wdata);
                chk("mem_size", mem_size, cur_size);
            end
            if (out_we) begin
                chk("out_addr", out_addr, cur_addr - 32'd516);
                chk("out_wdata", out_wdata, cur_wdata);
                chk("out_size", out_size, cur_size);
            end
            if (resp_valid) begin
                last_n = cmp_n;
                last_rdata = resp_rdata;
                last_err = resp_error;
            end
            if (cmp_n == cur.lat) begin
                chk("resp_rdata", resp_rdata, cur.rdata);
                chk("resp_error", resp_error, cur.err);
            end
        end else if (idle_chk) begin
            chk("idle_ready", req_ready, 1'b1);
            chk("idle_resp_valid", resp_valid, 1'b0);
            chk("idle_mem_we", mem_we, 1'b0);
            chk("idle_out_we", out_we, 1'b0);
        end
    end

    task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] wd);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", req_ready, 1'b1);
        req_addr = a; req_we = we; req_size = sz; req_signed = sg; req_wdata = wd;
        fault_clear = clr_on_accept;
        cur = model(a, we, sz, sg);
        cur_addr = a; cur_we = we; cur_size = sz; cur_wdata = wd;
        last_n = -1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc - 1;
        req_valid = 1'b0;
        fault_clear = 1'b0;
        active = 1'b1;
        repeat (cur.lat) @(negedge clk);
        #2;
        active = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
    endtask

    exp_t pin;
    int   we_before, owe_before;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_wdata = 32'h0; fault_clear = 1'b0;
        code_rdata = 32'h11223344; mem_rdata = 32'hDEADBEEF; in_rdata = 32'h00000080; out_rdata = 32'h0000A5A5;

        // Pin the model with hand-computed values.
        pin = model(32'h200, 1'b0, 2'b00, 1'b1);
        chk("pin_sbyte_rdata", pin.rdata, 32'hFFFFFF80);
        chk("pin_sbyte_lat", pin.lat, 4);
        pin = model(32'h102, 1'b0, 2'b10, 1'b0);
        chk("pin_misalign", {pin.err, pin.cause}, 3'b100);
        pin = model(32'hFFFFFFFF, 1'b0, 2'b10, 1'b0);
        chk("pin_wrap", {pin.err, pin.cause}, 3'b110);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_error", resp_error, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_out_we", out_we, 1'b0);
        chk("rst_fault_valid", fault_valid, 1'b0);
        #1 rst_n = 1'b1;
        idle_chk = 1'b1;
        @(negedge clk);

        // Word load from memory: response in cycle 3.
        do_req(32'h104, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t1_cycle", last_n, 3);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);
        chk("t1_error", last_err, 1'b0);

        // Signed / unsigned byte load from input: response in cycle 4.
        do_req(32'h200, 1'b0, 2'b00, 1'b1, 32'h0);
        chk("t2_cycle", last_n, 4);
        chk("t2_signed", last_rdata, 32'hFFFFFF80);
        do_req(32'h200, 1'b0, 2'b00, 1'b0, 32'h0);
        chk("t2_unsigned", last_rdata, 32'h00000080);
        mem_rdata = 32'h0000C001;
        do_req(32'h102, 1'b0, 2'b01, 1'b1, 32'h0);
        chk("t2_shalf", last_rdata, 32'hFFFFC001);

        // Half store to output: single out_we pulse in cycle 3.
        owe_before = out_we_cnt;
        do_req(32'h206, 1'b1, 2'b01, 1'b0, 32'h00001234);
        chk("t3_out_we_count", out_we_cnt - owe_before, 1);
        chk("t3_out_we_cycle", out_we_n, 3);
        chk("t3_out_addr", out_addr_seen, 32'h2);
        chk("t3_store_rdata", last_rdata, 32'h0);

        // Store to code: write-protect fault in cycle 1, no strobe.
        we_before = mem_we_cnt;
        owe_before = out_we_cnt;
        do_req(32'h10, 1'b1, 2'b10, 1'b0, 32'h55AA55AA);
        chk("t3_wp_cycle", last_n, 1);
        chk("t3_wp_error", last_err, 1'b1);
        chk("t3_wp_no_strobe", (mem_we_cnt - we_before) + (out_we_cnt - owe_before), 0);
`ifdef FAULT_CAPTURE_EN
        chk("t3_fault_valid", fault_valid, 1'b1);
        chk("t3_fault_cause", fault_cause, 2'b11);
        chk("t3_fault_addr", fault_addr, 32'h10);
`else
        chk("t3_fault_tied", {fault_valid, fault_cause, fault_addr}, 35'h0);
`endif

        // Alignment and region-boundary cases.
        do_req(32'h102, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t4_misalign_err", last_err, 1'b1);
        chk("t4_misalign_cycle", last_n, 1);
`ifdef FAULT_CAPTURE_EN
        chk("t4_keep_first", fault_addr, 32'h10);
`endif
        do_req(32'h002, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t4_code_unaligned_err", last_err, 1'b0);
        chk("t4_code_cycle", last_n, 2);
        chk("t4_code_rdata", last_rdata, 32'h11223344);
        do_req(32'h1FE, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t4_straddle_err", last_err, 1'b1);

        // Fault capture sequence.
        pulse_clear();
`ifdef FAULT_CAPTURE_EN
        chk("t5_cleared", fault_valid, 1'b0);
`endif
        do_req(32'h100, 1'b0, 2'b11, 1'b0, 32'h0);
        chk("t5_badsize_err", last_err, 1'b1);
        do_req(32'h300, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t5_unmapped_err", last_err, 1'b1);
`ifdef FAULT_CAPTURE_EN
        chk("t5_first_addr", fault_addr, 32'h100);
        chk("t5_first_cause", fault_cause, 2'b01);
`endif
        clr_on_accept = 1'b1;
        do_req(32'hFFFFFFFF, 1'b0, 2'b10, 1'b0, 32'h0);
        clr_on_accept = 1'b0;
        chk("t5_wrap_err", last_err, 1'b1);
`ifdef FAULT_CAPTURE_EN
        chk("t5_wrap_addr", fault_addr, 32'hFFFFFFFF);
        chk("t5_wrap_cause", fault_cause, 2'b10);
`else
        chk("t5_fault_tied", {fault_valid, fault_cause, fault_addr}, 35'h0);
`endif

        // Reset in the middle of a memory store drops the write.
        @(negedge clk);
        idle_chk = 1'b0;
        we_before = mem_we_cnt;
        req_addr = 32'h100; req_we = 1'b1; req_size = 2'b10; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t6_pre_we", mem_we, 1'b0);
        chk("t6_pre_ready", req_ready, 1'b0);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_rst_we", mem_we, 1'b0);
            chk("t6_rst_ready", req_ready, 1'b1);
            chk("t6_rst_resp", resp_valid, 1'b0);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_ready", req_ready, 1'b1);
        #1;
        chk("t6_no_strobe", mem_we_cnt, we_before);
`ifdef FAULT_CAPTURE_EN
        chk("t6_fault_cleared", fault_valid, 1'b0);
`endif
        idle_chk = 1'b1;
        mem_rdata = 32'h0BADF00D;
        do_req(32'h104, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t6_next_cycle", last_n, 3);
        chk("t6_next_rdata", last_rdata, 32'h0BADF00D);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end
endmodule
